// File: rtl/exec_mdu_if.sv
// E-stage multiply/divide unit interface: operands and op code in,
// busy flag, HI/LO state and MFHI/MFLO read data out.
interface exec_mdu_if;
    logic [31:0] v_A_E;
    logic [31:0] v_B_E;
    logic [3:0]  mdu_op_E;
    logic        start_E;
    logic        busy;
    logic [31:0] v_HI;
    logic [31:0] v_LO;
    logic [31:0] v_MDUout_E;

    modport master (
        output v_A_E, v_B_E, mdu_op_E, start_E,
        input  busy, v_HI, v_LO, v_MDUout_E
    );

    modport slave (
        input  v_A_E, v_B_E, mdu_op_E, start_E,
        output busy, v_HI, v_LO, v_MDUout_E
    );
endinterface

// File: rtl/exec_mdu.sv
// Multi-cycle MIPS-style HI/LO unit: the result is computed at start, held for a
// fixed busy window, then committed to HI/LO. MFHI/MFLO reads are combinational.
module exec_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    exec_mdu_if.slave   mdu
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0]      r_hi, r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [3:0]       r_op;
    logic [63:0]      r_res;
    logic             r_dz;

    logic [31:0] w_a, w_b, w_div_b;
    logic        w_ovf, w_bz, w_is_div, w_is_start;
    logic [63:0] w_prod_s, w_prod_u, w_res;
    logic [31:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;

    assign w_a        = mdu.v_A_E;
    assign w_b        = mdu.v_B_E;
    assign w_bz       = (w_b == 32'd0);
    assign w_is_div   = (mdu.mdu_op_E == OP_DIV) || (mdu.mdu_op_E == OP_DIVU);
    assign w_is_start = mdu.start_E && (mdu.mdu_op_E >= OP_MULT) && (mdu.mdu_op_E <= OP_DIVU);

    // INT_MIN / -1 and x / 0 never reach the dividers: a divisor of 1 yields
    // the required 0x80000000 rem 0 for overflow, and the /0 result is discarded.
    assign w_ovf   = (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
    assign w_div_b = (w_bz || w_ovf) ? 32'd1 : w_b;

    assign w_prod_s = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
    assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};
    assign w_quo_s  = $signed(w_a) / $signed(w_div_b);
    assign w_rem_s  = $signed(w_a) % $signed(w_div_b);
    assign w_quo_u  = w_a / w_div_b;
    assign w_rem_u  = w_a % w_div_b;

    always_comb begin
        w_res = 64'd0;
        case (mdu.mdu_op_E)
            OP_MULT:  w_res = w_prod_s;
            OP_MULTU: w_res = w_prod_u;
            OP_DIV:   w_res = {w_rem_s, w_quo_s};
            OP_DIVU:  w_res = {w_rem_u, w_quo_u};
            default:  w_res = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_op   <= 4'd0;
            r_res  <= 64'd0;
            r_dz   <= 1'b0;
        end else if (r_busy) begin
            // Inputs are ignored while busy; only the countdown advances.
            if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (!(r_dz && ((r_op == OP_DIV) || (r_op == OP_DIVU)))) begin
                    r_hi <= r_res[63:32];
                    r_lo <= r_res[31:0];
                end
            end
        end else if (w_is_start) begin
            r_busy <= 1'b1;
            r_op   <= mdu.mdu_op_E;
            r_res  <= w_res;
            r_dz   <= w_is_div && w_bz;
            r_cnt  <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (mdu.mdu_op_E == OP_MTHI) begin
            r_hi <= w_a;
        end else if (mdu.mdu_op_E == OP_MTLO) begin
            r_lo <= w_a;
        end
    end

    assign mdu.busy       = r_busy;
    assign mdu.v_HI       = r_hi;
    assign mdu.v_LO       = r_lo;
    assign mdu.v_MDUout_E = (mdu.mdu_op_E == OP_MFHI) ? r_hi :
                            (mdu.mdu_op_E == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_exec_mdu.sv
// Directed bench for exec_mdu: reset state, MT/MF moves, mult/div results,
// busy window length, divide-by-zero, ignored writes while busy, mid-op reset.
module tb_exec_mdu;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exec_mdu_if mif ();
    exec_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .mdu(mif));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st);
        mif.mdu_op_E = op;
        mif.v_A_E    = a;
        mif.v_B_E    = b;
        mif.start_E  = st;
    endtask

    // Start an op, expect busy for exactly n sampled cycles with HI/LO held, then the result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        old_hi = mif.v_HI;
        old_lo = mif.v_LO;
        drive(op, a, b, 1'b1);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, 32'(mif.busy), 32'd1);
            if (i == n - 1) begin
                check({tag, " hi held"}, mif.v_HI, old_hi);
                check({tag, " lo held"}, mif.v_LO, old_lo);
            end
            tick();
        end
        check({tag, " done"}, 32'(mif.busy), 32'd0);
        check({tag, " hi"}, mif.v_HI, exp_hi);
        check({tag, " lo"}, mif.v_LO, exp_lo);
    endtask

    initial begin
        reset = 1'b1;
        drive(4'd1, 32'h1111_1111, 32'h2222_2222, 1'b1);
        tick();
        tick();
        check("reset busy", 32'(mif.busy), 32'd0);
        check("reset hi", mif.v_HI, 32'd0);
        check("reset lo", mif.v_LO, 32'd0);
        for (int op = 0; op < 16; op++) begin
            mif.mdu_op_E = 4'(op);
            #1;
            check($sformatf("reset mduout op%0d", op), mif.v_MDUout_E, 32'd0);
        end
        reset = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        tick();

        drive(4'd7, 32'h0000_1234, 32'd0, 1'b0);
        tick();
        drive(4'd8, 32'h0000_5678, 32'd0, 1'b0);
        tick();
        check("mthi hi", mif.v_HI, 32'h0000_1234);
        check("mtlo lo", mif.v_LO, 32'h0000_5678);
        check("mt busy", 32'(mif.busy), 32'd0);
        drive(4'd5, 32'd0, 32'd0, 1'b0);
        #1;
        check("mfhi out", mif.v_MDUout_E, 32'h0000_1234);
        drive(4'd6, 32'd0, 32'd0, 1'b0);
        #1;
        check("mflo out", mif.v_MDUout_E, 32'h0000_5678);
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("none out", mif.v_MDUout_E, 32'd0);

        run_op("divu by0", 4'd4, 32'h0000_0064, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);
        run_op("div by0", 4'd3, 32'hFFFF_FFF9, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("div neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("div negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E);
        run_op("mult pos", 4'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);

        // MULTU with an MTLO and a competing DIV start injected mid-flight.
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("multu busy", 32'(mif.busy), 32'd1);
            if (i == 1) drive(4'd8, 32'h0000_ABCD, 32'd0, 1'b0);
            else if (i == 2) drive(4'd3, 32'd9, 32'd2, 1'b1);
            else drive(4'd0, 32'd0, 32'd0, 1'b0);
            tick();
            if (i == 1) check("mtlo while busy", mif.v_LO, 32'h0000_0000);
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        check("multu done", 32'(mif.busy), 32'd0);
        check("multu hi", mif.v_HI, 32'hFFFF_FFFE);
        check("multu lo", mif.v_LO, 32'h0000_0001);
        tick();
        check("no restart", 32'(mif.busy), 32'd0);
        drive(4'd6, 32'd0, 32'd0, 1'b0);
        #1;
        check("mflo idle", mif.v_MDUout_E, 32'h0000_0001);

        drive(4'd9, 32'd5, 32'd5, 1'b1);
        tick();
        check("start op9", 32'(mif.busy), 32'd0);
        drive(4'd0, 32'd5, 32'd5, 1'b1);
        tick();
        check("start op0", 32'(mif.busy), 32'd0);
        check("start op0 lo", mif.v_LO, 32'h0000_0001);

        // Reset in the third busy cycle of a MULT.
        drive(4'd1, 32'd5, 32'd7, 1'b1);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        check("pre-reset busy", 32'(mif.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", 32'(mif.busy), 32'd0);
        check("midreset hi", mif.v_HI, 32'd0);
        check("midreset lo", mif.v_LO, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("postreset busy", 32'(mif.busy), 32'd0);
        check("postreset hi", mif.v_HI, 32'd0);
        check("postreset lo", mif.v_LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_mdu.md
EXEC_MDU -- requirements
Module: exec_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU, in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, in cycles.
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 v_A_E  input  32  rs operand, already forwarded, in E stage.
REQ-006 v_B_E  input  32  rt operand, already forwarded, in E stage.
REQ-007 mdu_op_E  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 behave as NONE.
REQ-008 start_E  input  1  high for exactly one cycle when mdu_op_E is 1-4 and the E instruction is valid.
REQ-009 busy  output  1  high while a mult/div is in flight.
REQ-010 v_HI  output  32  current HI register.
REQ-011 v_LO  output  32  current LO register.
REQ-012 v_MDUout_E  output  32  read result for MFHI/MFLO, muxed by hazard/forward logic into v_ALUout_EM.

Function
REQ-013 Registers: HI, LO (32 b each), counter (4 b minimum), busy flag, latched operation, latched 64-bit result.
REQ-014 Idle state (busy=0), start_E=1 with op 1-4 at edge E0: compute the result from v_A_E/v_B_E at E0, latch it, load counter with MULT_CYCLES or DIV_CYCLES, set busy=1.
REQ-015 Busy state: counter decrements each edge; on the edge where counter goes 1->0, write HI/LO from the latched result and clear busy.
REQ-016 Latency: busy is high for exactly N cycles after the start cycle; new HI/LO are visible in the first cycle with busy=0.
REQ-017 MULT: {HI,LO} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-018 DIV: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend.
REQ-019 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-020 DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-021 Divide by zero (DIV or DIVU): full busy period runs, then HI and LO are left unchanged.
REQ-022 MTHI/MTLO while idle: HI (or LO) <= v_A_E at the edge, with no busy.
REQ-023 MTHI/MTLO/start_E while busy: ignored, no state change (the hazard unit stalls these, so this is a defensive case only).
REQ-024 start_E with op not in 1-4: ignored.
REQ-025 v_MDUout_E is combinational: HI when op=5, LO when op=6, otherwise 0.
REQ-026 MFHI/MFLO read the current HI/LO registers regardless of busy.
REQ-027 The hazard unit stalls any MDU-op instruction in E while (start_E | busy).
REQ-028 exec_mdu performs no internal stall handling.
REQ-029 Inputs are stable during stall; start_E is only asserted for one cycle per instruction.
REQ-030 Counter wrap: never decrements below 0 and never reloads while busy.

Reset
REQ-031 Reset has priority over all inputs.
REQ-032 On reset: HI=0, LO=0, counter=0, busy=0, latched op/result cleared.
REQ-033 Outputs after reset: busy=0, v_HI=0, v_LO=0; v_MDUout_E=0 for every op.
REQ-034 Reset mid-operation discards the in-flight result: HI/LO stay 0 after reset deasserts and busy does not resume.

Verification
REQ-035 MULT A=0xFFFFFFFE (-2), B=3, start 1 cycle -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 DIVU with B=0, after prior MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
REQ-040 MULT started, reset at 3rd busy cycle -> next cycle busy=0, HI=LO=0, and they remain 0.
REQ-041 MTLO 0xABCD while busy -> LO unaffected.
REQ-042 MFLO op=6 in idle -> v_MDUout_E=LO in the same cycle.
